mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_pick.sv | 16 +
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the byte-serial memory port arbiter: access sizes,
// FSM states, requester identities and the size-to-byte-count mapping.
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    ACK  = 2'b10,
    ERR  = 2'b11
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Reserved size maps to zero bytes; it never reaches XFER.
  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_count = 3'd1;
      SZ_HALF: size_to_count = 3'd2;
      SZ_WORD: size_to_count = 3'd4;
      default: size_to_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way round-robin picker: with both requesting, the owner
// that was not granted last wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output logic   gnt_if,
  output logic   gnt_d
);

  assign gnt_d  = d_req  && (!if_req || (last_grant == OWN_IF));
  assign gnt_if = if_req && (!d_req  || (last_grant == OWN_D));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between instruction fetch and data access,
// running each access as a big-endian byte burst with a one-cycle acknowledge.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  logic [ADDR_W-1:0] base;
  logic [2:0]        count;
  logic [1:0]        k;
  logic              rw;
  logic [31:0]       wdata;
  logic [23:0]       sr;
  logic [31:0]       sr_next;
  logic              last_byte;
  logic [1:0]        byte_sel;
  logic [7:0]        wr_byte;
  logic              gnt_if;
  logic              gnt_d;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .gnt_if     (gnt_if),
    .gnt_d      (gnt_d)
  );

  assign sr_next   = {sr, mem_rdata};
  assign last_byte = (({1'b0, k} + 3'd1) == count);
  assign byte_sel  = 2'(count - 3'd1 - {1'b0, k});

  // Byte k of an n-byte store is the (n-1-k)th byte from the bottom: MSB first.
  always_comb begin
    wr_byte = wdata[7:0];
    case (byte_sel)
      2'd1:    wr_byte = wdata[15:8];
      2'd2:    wr_byte = wdata[23:16];
      2'd3:    wr_byte = wdata[31:24];
      default: wr_byte = wdata[7:0];
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == XFER);
  assign mem_we    = mem_en && rw;
  assign mem_addr  = mem_en ? (base + ADDR_W'(k)) : '0;
  assign mem_wdata = mem_en ? wr_byte : '0;
  assign if_ack    = (state == ACK) && (owner == OWN_IF);
  assign d_ack     = ((state == ACK) && (owner == OWN_D)) || (state == ERR);
  assign d_err     = (state == ERR);

  // last_grant resets to the fetch side so the first contended grant goes to data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      base       <= '0;
      count      <= '0;
      k          <= '0;
      rw         <= 1'b0;
      wdata      <= '0;
      sr         <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_d) begin
            owner <= OWN_D;
            base  <= d_addr;
            count <= size_to_count(d_size);
            rw    <= d_rw;
            wdata <= d_wdata;
            k     <= '0;
            sr    <= '0;
            if (d_size == SZ_RSVD) begin
              d_rdata <= '0;
              state   <= ERR;
            end else begin
              state   <= XFER;
            end
          end else if (gnt_if) begin
            owner <= OWN_IF;
            base  <= if_addr & ~ADDR_W'(3);
            count <= 3'd4;
            rw    <= 1'b0;
            wdata <= '0;
            k     <= '0;
            sr    <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          sr <= sr_next[23:0];
          if (last_byte) begin
            if (owner == OWN_IF) begin
              if_rdata <= sr_next;
            end else begin
              d_rdata  <= sr_next;
            end
            state <= ACK;
          end else begin
            k <= k + 2'd1;
          end
        end
        ACK: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        ERR: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a transaction-level schedule model predicts every cycle's
// outputs, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_size = '0;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_rw      (d_rw),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory array the DUT drives: combinational read, write at the rising edge.
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: no acknowledge within the cycle budget", name);
  endtask

  // Expected outputs for one clock cycle; a granted access expands into a list.
  typedef struct packed {
    logic        busy;
    logic        en;
    logic        we;
    logic        chk_wd;
    logic        ifa;
    logic        da;
    logic        de;
    logic        chk_rd;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t       sched[$];
  exp_t       cur;
  logic [7:0] gold [256];
  bit         prefer_d;

  task automatic plan(input bit is_if, input logic rw, input logic [1:0] sz,
                      input logic [7:0] a, input logic [31:0] wd);
    exp_t        e;
    int          n;
    logic [31:0] rd;
    rd = '0;
    if (!is_if && sz == 2'b11) begin
      e = '0; e.busy = 1'b1; e.da = 1'b1; e.de = 1'b1; e.chk_rd = 1'b1; e.rdata = '0;
      sched.push_back(e);
    end else begin
      n = is_if ? 4 : (sz == 2'b00 ? 1 : (sz == 2'b01 ? 2 : 4));
      for (int j = 0; j < n; j++) begin
        e = '0;
        e.busy = 1'b1; e.en = 1'b1; e.we = rw; e.chk_wd = rw;
        e.addr  = a + 8'(j);
        e.wdata = 8'(wd >> (8 * (n - 1 - j)));
        rd = rd + (32'(gold[e.addr]) << (8 * (n - 1 - j)));
        sched.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.ifa = is_if; e.da = !is_if; e.chk_rd = !rw; e.rdata = rd;
      sched.push_back(e);
    end
    e = '0;
    sched.push_back(e);
  endtask

  task automatic compare_cycle();
    if (!reset_n) begin
      check_output("rst busy", busy, 0);
      check_output("rst mem_en", mem_en, 0);
      check_output("rst mem_we", mem_we, 0);
      check_output("rst mem_addr", mem_addr, 0);
      check_output("rst mem_wdata", mem_wdata, 0);
      check_output("rst if_ack", if_ack, 0);
      check_output("rst d_ack", d_ack, 0);
      check_output("rst d_err", d_err, 0);
      check_output("rst if_rdata", if_rdata, 0);
      check_output("rst d_rdata", d_rdata, 0);
    end else begin
      check_output("busy", busy, cur.busy);
      check_output("mem_en", mem_en, cur.en);
      check_output("mem_we", mem_we, cur.we);
      check_output("if_ack", if_ack, cur.ifa);
      check_output("d_ack", d_ack, cur.da);
      check_output("d_err", d_err, cur.de);
      if (cur.en) check_output("mem_addr", mem_addr, cur.addr);
      if (cur.chk_wd) check_output("mem_wdata", mem_wdata, cur.wdata);
      if (cur.ifa && cur.chk_rd) check_output("if_rdata", if_rdata, cur.rdata);
      if (cur.da && cur.chk_rd) check_output("d_rdata", d_rdata, cur.rdata);
    end
  endtask

  // Model and compare: step the schedule at each edge, check 1 time unit later.
  initial begin
    for (int i = 0; i < 256; i++) gold[i] = 8'(i) ^ 8'h5A;
    prefer_d = 1'b1;
    cur = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        sched.delete();
        prefer_d = 1'b1;
        cur = '0;
      end else begin
        if (cur.we) gold[cur.addr] = cur.wdata;
        if (sched.size() == 0) begin
          if (d_req && (!if_req || prefer_d)) begin
            plan(1'b0, d_rw, d_size, d_addr, d_wdata);
            prefer_d = 1'b0;
          end else if (if_req) begin
            plan(1'b1, 1'b0, 2'b10, if_addr & 8'hFC, '0);
            prefer_d = 1'b1;
          end
        end
        if (sched.size() != 0) cur = sched.pop_front();
        else cur = '0;
      end
      #1;
      compare_cycle();
    end
  end

  task automatic apply_stimulus(input bit do_if, input logic [7:0] ia,
                                input bit do_d, input logic rw, input logic [1:0] sz,
                                input logic [7:0] da, input logic [31:0] wd,
                                output int if_cyc, output int d_cyc,
                                output logic [31:0] if_dat, output logic [31:0] d_dat,
                                output logic d_e, output bit en_seen);
    if_cyc = -1; d_cyc = -1; if_dat = '0; d_dat = '0; d_e = 1'b0; en_seen = 1'b0;
    @(negedge clk);
    if (do_if) begin if_req = 1'b1; if_addr = ia; end
    if (do_d) begin d_req = 1'b1; d_rw = rw; d_size = sz; d_addr = da; d_wdata = wd; end
    for (int cyc = 1; cyc <= 20 && (if_req || d_req); cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_en) en_seen = 1'b1;
      if (if_req && if_ack) begin if_cyc = cyc; if_dat = if_rdata; if_req = 1'b0; end
      if (d_req && d_ack) begin d_cyc = cyc; d_dat = d_rdata; d_e = d_err; d_req = 1'b0; end
    end
    if (if_req || d_req) begin
      fail_timeout("directed access");
      if_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic rand_d();
    int budget;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    d_req   = 1'b1;
    d_rw    = 1'($urandom_range(0, 1));
    d_size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    d_addr  = 8'($urandom);
    d_wdata = $urandom;
    budget = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      budget++;
    end while (!d_ack && budget < 40);
    if (!d_ack) fail_timeout("random data access");
    d_req = 1'b0;
  endtask

  task automatic rand_if();
    int budget;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 8'($urandom);
    budget = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      budget++;
    end while (!if_ack && budget < 40);
    if (!if_ack) fail_timeout("random fetch");
    if_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          ic, dc;
    logic [31:0] idat, ddat;
    logic        derr;
    bit          en_seen;
    bit          ack_seen;

    $display("[TB] start");
    repeat (3) @(negedge clk);
    check_output("reset busy", busy, 0);
    check_output("reset mem_en", mem_en, 0);
    check_output("reset d_ack", d_ack, 0);
    check_output("reset if_rdata", if_rdata, 0);
    reset_n = 1'b1;

    // Contended pair straight after reset: data first, fetch six cycles later.
    apply_stimulus(1, 8'h07, 1, 1'b0, 2'b00, 8'h20, '0, ic, dc, idat, ddat, derr, en_seen);
    check_output("pair1 d cycle", dc, 2);
    check_output("pair1 d data", ddat, 32'h0000_007A);
    check_output("pair1 if cycle", ic, 8);
    check_output("pair1 if data", idat, 32'h5E5F_5C5D);

    apply_stimulus(0, '0, 1, 1'b1, 2'b10, 8'h10, 32'hDEAD_BEEF, ic, dc, idat, ddat, derr, en_seen);
    check_output("word store cycle", dc, 5);
    check_output("word store b0", mem[8'h10], 8'hDE);
    check_output("word store b1", mem[8'h11], 8'hAD);
    check_output("word store b2", mem[8'h12], 8'hBE);
    check_output("word store b3", mem[8'h13], 8'hEF);

    // Last grant was data, so this pair is served fetch first.
    apply_stimulus(1, 8'h31, 1, 1'b0, 2'b00, 8'h10, '0, ic, dc, idat, ddat, derr, en_seen);
    check_output("pair2 if cycle", ic, 5);
    check_output("pair2 if data", idat, 32'h6A6B_6869);
    check_output("pair2 d cycle", dc, 8);
    check_output("pair2 d data", ddat, 32'h0000_00DE);

    apply_stimulus(0, '0, 1, 1'b1, 2'b01, 8'hFF, 32'h0000_1234, ic, dc, idat, ddat, derr, en_seen);
    check_output("half store cycle", dc, 3);
    apply_stimulus(0, '0, 1, 1'b0, 2'b01, 8'hFF, '0, ic, dc, idat, ddat, derr, en_seen);
    check_output("half load cycle", dc, 3);
    check_output("half load data", ddat, 32'h0000_1234);

    apply_stimulus(0, '0, 1, 1'b0, 2'b11, 8'h50, '0, ic, dc, idat, ddat, derr, en_seen);
    check_output("rsvd cycle", dc, 1);
    check_output("rsvd err", derr, 1);
    check_output("rsvd data", ddat, 0);
    check_output("rsvd mem_en seen", en_seen, 0);

    // Word store cut by reset during its third byte.
    @(negedge clk);
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_addr = 8'h40; d_wdata = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("abort busy", busy, 0);
    check_output("abort mem_en", mem_en, 0);
    check_output("abort mem_we", mem_we, 0);
    check_output("abort d_ack", d_ack, 0);
    d_req = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack || if_ack) ack_seen = 1'b1;
    end
    check_output("abort ack seen", ack_seen, 0);
    check_output("abort b0", mem[8'h40], 8'h11);
    check_output("abort b1", mem[8'h41], 8'h22);
    check_output("abort b2", mem[8'h42], 8'h18);
    check_output("abort b3", mem[8'h43], 8'h19);
    reset_n = 1'b1;
    apply_stimulus(1, 8'h42, 0, 1'b0, 2'b00, '0, '0, ic, dc, idat, ddat, derr, en_seen);
    check_output("post-reset fetch cycle", ic, 5);
    check_output("post-reset fetch data", idat, 32'h1122_1819);

    fork
      begin
        for (int t = 0; t < 150; t++) rand_if();
      end
      begin
        for (int t = 0; t < 150; t++) rand_d();
      end
    join

    repeat (4) @(negedge clk);
    for (int i = 0; i < 256; i++) check_output($sformatf("final mem[%0d]", i), mem[i], gold[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
